// File: rtl/streamer_pkg.sv
// Shared types and constants for the port-2 read streamer.
package streamer_pkg;
    localparam int ADDR_W     = 20;
    localparam int DATA_W     = 16;
    localparam int RAM_OFFSET = 76;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;
endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry buffer between the registered memory read and the consumer handshake.
module stream_skid_fifo #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occ
);
    logic [DATA_W-1:0] e0;
    logic [DATA_W-1:0] e1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0  <= '0;
            e1  <= '0;
            occ <= 2'd0;
        end else if (clr) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) e0 <= din;
                    else             e1 <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    // occupancy is unchanged; the new word lands behind whatever remains
                    if (occ == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = e0;
endmodule

// File: rtl/mem_port2_streamer.sv
// Walks a block of port-2 words and emits them as a valid/ready stream.
module mem_port2_streamer #(
    parameter int ADDR_W = streamer_pkg::ADDR_W,
    parameter int DATA_W = streamer_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [ADDR_W-1:0] wordCount,
    output logic [ADDR_W-1:0] address2,
    input  logic [DATA_W-1:0] qb,
    output logic [DATA_W-1:0] outData,
    output logic              outValid,
    input  logic              outReady,
    output logic              busy,
    output logic              done
);
    import streamer_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] count_r;
    logic [ADDR_W-1:0] issue_cnt;
    logic [ADDR_W-1:0] pop_cnt;
    logic [ADDR_W-1:0] addr_hold;
    logic [ADDR_W-1:0] addr_sum;
    logic              inflight;
    logic [1:0]        occ;
    logic              pop;
    logic              issue;
    logic              last_pop;
    logic              clr;
    logic [2:0]        pending;
    logic [2:0]        limit;

    assign pop      = outValid & outReady;
    assign addr_sum = base_r + issue_cnt;
    // outside RUN the port keeps the last address it showed
    assign address2 = (state == RUN) ? addr_sum : addr_hold;
    assign pending  = {1'b0, occ} + {2'b00, inflight};
    assign limit    = 3'd2 + {2'b00, pop};
    assign issue    = (state == RUN) && (issue_cnt < count_r) && (pending < limit);
    assign last_pop = pop && ((pop_cnt + {{(ADDR_W-1){1'b0}}, 1'b1}) == count_r);
    assign clr      = (state == IDLE) && start;
    assign outValid = (occ != 2'd0);

    stream_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .push (inflight),
        .pop  (pop),
        .din  (qb),
        .head (outData),
        .occ  (occ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            base_r    <= '0;
            count_r   <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            addr_hold <= '0;
            inflight  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base_r    <= baseAddr;
                        count_r   <= wordCount;
                        issue_cnt <= '0;
                        pop_cnt   <= '0;
                        inflight  <= 1'b0;
                        busy      <= 1'b1;
                        if (wordCount == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    inflight  <= issue;
                    addr_hold <= addr_sum;
                    if (issue) issue_cnt <= issue_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (pop)   pop_cnt   <= pop_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (last_pop) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port2_streamer.sv
// Directed bench for mem_port2_streamer with a word scoreboard and port-2 memory model.
module tb_mem_port2_streamer;
    import streamer_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] baseAddr = '0;
    logic [ADDR_W-1:0] wordCount = '0;
    logic [ADDR_W-1:0] address2;
    logic [DATA_W-1:0] qb = '0;
    logic [DATA_W-1:0] outData;
    logic              outValid;
    logic              outReady = 1'b0;
    logic              busy;
    logic              done;

    int                total = 0;
    int                bad = 0;
    logic [DATA_W-1:0] sb[$];
    int                mon_pops = 0;
    int                pops_base = 0;
    int                done_cnt = 0;
    logic [ADDR_W-1:0] cur_base = '0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    mem_port2_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .baseAddr  (baseAddr),
        .wordCount (wordCount),
        .address2  (address2),
        .qb        (qb),
        .outData   (outData),
        .outValid  (outValid),
        .outReady  (outReady),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] memval(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0]   phys;
        logic [DATA_W-1:0] k;
        phys = {1'b0, a} + (ADDR_W+1)'(RAM_OFFSET);
        if (a >= 10 && a <= 13) begin
            k = DATA_W'(a - 9);
            return 16'h0011 * k;
        end
        return phys[DATA_W-1:0] ^ 16'h5A5A;
    endfunction

    // registered read: data for the address shown this cycle appears next cycle
    always @(posedge clk) qb <= memval(address2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [DATA_W-1:0] exp;
        logic [ADDR_W-1:0] diff;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (prev_stall) begin
                chk("stall_valid", {31'b0, outValid}, 32'd1);
                chk("stall_data", {16'b0, outData}, {16'b0, prev_data});
            end
            if (outValid && outReady) begin
                exp = (sb.size() != 0) ? sb.pop_front() : ~outData;
                chk("word", {16'b0, outData}, {16'b0, exp});
                mon_pops <= mon_pops + 1;
            end
            if (busy && !done) begin
                diff = address2 - cur_base;
                chk("ahead", {31'b0, (int'(diff) <= (mon_pops - pops_base) + 2)}, 32'd1);
            end
            prev_stall <= outValid && !outReady;
            prev_data  <= outData;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
        baseAddr  = b;
        wordCount = n;
        start     = 1'b1;
        cur_base  = b;
        pops_base = mon_pops;
        for (int i = 0; i < int'(n); i++) sb.push_back(memval(b + ADDR_W'(i)));
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit && !done; i++) step();
        chk({tag, "_done_seen"}, {31'b0, done}, 32'd1);
        step();
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    initial begin
        int d0;
        logic [ADDR_W-1:0] a_before;

        // reset state
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_valid", {31'b0, outValid}, 32'd0);
        chk("rst_data", {16'b0, outData}, 32'd0);
        chk("rst_addr", {12'b0, address2}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // streaming with consumer always ready: exact cycle timing
        outReady = 1'b1;
        d0 = done_cnt;
        start_xfer(20'd10, 20'd4);
        chk("t1_addr0", {12'b0, address2}, 32'd10);
        for (int k = 1; k <= 8; k++) begin
            chk("t1_valid", {31'b0, outValid}, {31'b0, (k >= 3 && k <= 6)});
            chk("t1_done", {31'b0, done}, {31'b0, (k == 7)});
            chk("t1_busy", {31'b0, busy}, {31'b0, (k <= 7)});
            if (k == 3) chk("t1_first", {16'b0, outData}, 32'h11);
            step();
        end
        chk("t1_done_cnt", done_cnt - d0, 32'd1);
        chk("t1_sb_empty", sb.size(), 32'd0);

        // back-pressure pattern 1,0,0,1
        d0 = done_cnt;
        outReady = 1'b1;
        start_xfer(20'd10, 20'd4);
        for (int i = 0; i < 60 && !done; i++) begin
            outReady = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        outReady = 1'b1;
        wait_done("t2", 5);
        chk("t2_done_cnt", done_cnt - d0, 32'd1);

        // empty transfer
        d0 = done_cnt;
        a_before = address2;
        start_xfer(20'd55, 20'd0);
        chk("t3_done", {31'b0, done}, 32'd1);
        chk("t3_addr", {12'b0, address2}, {12'b0, a_before});
        for (int k = 0; k < 3; k++) begin
            chk("t3_novalid", {31'b0, outValid}, 32'd0);
            step();
        end
        chk("t3_addr_after", {12'b0, address2}, {12'b0, a_before});
        chk("t3_done_cnt", done_cnt - d0, 32'd1);

        // address wrap at the top of the port-2 space
        start_xfer(20'hFFFFE, 20'd4);
        chk("t4_a0", {12'b0, address2}, 32'hFFFFE);
        step();
        chk("t4_a1", {12'b0, address2}, 32'hFFFFF);
        step();
        chk("t4_a2", {12'b0, address2}, 32'h00000);
        step();
        chk("t4_a3", {12'b0, address2}, 32'h00001);
        wait_done("t4", 20);

        // start during a transfer is ignored
        d0 = done_cnt;
        start_xfer(20'd20, 20'd5);
        step();
        baseAddr  = 20'd40;
        wordCount = 20'd2;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_done("t5", 30);
        chk("t5_done_cnt", done_cnt - d0, 32'd1);

        // asynchronous reset after two words, then a clean restart
        d0 = done_cnt;
        start_xfer(20'd30, 20'd6);
        for (int i = 0; i < 30 && (mon_pops - pops_base) < 2; i++) step();
        chk("t6_two_popped", mon_pops - pops_base, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid_fall", {31'b0, outValid}, 32'd0);
        chk("t6_busy_fall", {31'b0, busy}, 32'd0);
        chk("t6_done_low", {31'b0, done}, 32'd0);
        chk("t6_addr_rst", {12'b0, address2}, 32'd0);
        sb.delete();
        step();
        rst = 1'b0;
        step();
        step();
        chk("t6_no_done", done_cnt - d0, 32'd0);
        start_xfer(20'd30, 20'd6);
        chk("t6_restart_addr", {12'b0, address2}, 32'd30);
        wait_done("t6", 30);
        chk("t6_done_cnt", done_cnt - d0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
